// File: rtl/prio_sel_gen.sv
// prio_sel_gen: walks a 32-bit hit mask LSB-first, emitting one select index per cycle, then a done pulse with the hit count
module prio_sel_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_mask,
  input  logic        out_ready,
  output logic        sel_valid,
  output logic [4:0]  sel,
  output logic        sel_last,
  output logic        done,
  output logic [5:0]  hit_count
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t      state, state_n;
  logic [31:0] mask_r, mask_n, src, rest;
  logic [5:0]  cnt_r, cnt_n, hit_n;
  logic [4:0]  sel_n;
  logic        sel_valid_n, sel_last_n, done_n, load, empty, step, fin, pick;
  function automatic logic [4:0] ffs(input logic [31:0] m);
    ffs = '0;
    for (int i = 31; i >= 0; i--) if (m[i]) ffs = 5'(i);
  endfunction
  assign in_ready = state == IDLE;
  always_comb begin
    load        = in_ready && in_valid;
    empty       = in_mask == '0;
    step        = state == SCAN && out_ready && !sel_last;
    fin         = state == SCAN && out_ready && sel_last;
    pick        = (load && !empty) || step;
    src         = load ? in_mask : mask_r;
    rest        = src & (src - 32'd1);
    sel_n       = pick ? ffs(src) : fin ? 5'd0 : sel;
    mask_n      = pick ? rest : mask_r;
    sel_last_n  = pick ? rest == '0 : fin ? 1'b0 : sel_last;
    cnt_n       = load ? 6'd1 : step ? cnt_r + 6'd1 : cnt_r;
    done_n      = (load && empty) || fin;
    hit_n       = load && empty ? 6'd0 : fin ? cnt_r : hit_count;
    sel_valid_n = pick || (sel_valid && !fin);
    state_n     = sel_valid_n ? SCAN : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_r    <= '0;
      cnt_r     <= '0;
      sel_valid <= 1'b0;
      sel       <= '0;
      sel_last  <= 1'b0;
      done      <= 1'b0;
      hit_count <= '0;
    end else begin
      state     <= state_n;
      mask_r    <= mask_n;
      cnt_r     <= cnt_n;
      sel_valid <= sel_valid_n;
      sel       <= sel_n;
      sel_last  <= sel_last_n;
      done      <= done_n;
      hit_count <= hit_n;
    end
  end
endmodule

// File: tb/tb_prio_sel_gen.sv
// tb_prio_sel_gen: directed stimulus with a queue-based reference model checked every cycle
module tb_prio_sel_gen;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [31:0] in_mask = '0;
  logic        in_ready, sel_valid, sel_last, done;
  logic [4:0]  sel;
  logic [5:0]  hit_count;
  int n_chk = 0, n_fail = 0;
  int q[$];
  bit m_busy = 0, m_done = 0, started = 0;
  int m_hits = 0, m_emit = 0;

  prio_sel_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_ready(out_ready), .sel_valid(sel_valid), .sel(sel), .sel_last(sel_last),
    .done(done), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the list of set-bit indices, consumed front-first.
  always @(posedge clk) begin
    bit nd;
    started = 1;
    nd = 0;
    if (rst) begin
      q.delete();
      m_busy = 0;
      m_hits = 0;
      m_emit = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        for (int i = 0; i < 32; i++) if (in_mask[i]) q.push_back(i);
        if (q.size() == 0) begin
          nd = 1;
          m_hits = 0;
        end else begin
          m_busy = 1;
          m_emit = 1;
        end
      end
    end else if (out_ready) begin
      if (q.size() == 1) begin
        q.delete();
        m_busy = 0;
        nd = 1;
        m_hits = m_emit;
      end else begin
        void'(q.pop_front());
        m_emit++;
      end
    end
    m_done = nd;
  end

  always @(negedge clk) if (started) begin
    chk("in_ready", in_ready, !m_busy);
    chk("sel_valid", sel_valid, m_busy);
    chk("sel", sel, m_busy ? q[0] : 0);
    chk("sel_last", sel_last, m_busy && q.size() == 1);
    chk("done", done, m_done);
    if (m_done) chk("hit_count", hit_count, m_hits);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] m);
    int k;
    in_valid = 1;
    in_mask = m;
    tick();
    in_valid = 0;
    k = 0;
    while (!done && k < 200) begin
      out_ready = (k % 3) != 1;
      tick();
      k++;
    end
    chk("frame_done_in_time", k < 200, 1);
    chk("frame_hits", hit_count, $countones(m));
    out_ready = 1;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_done", done, 0);
    chk("rst_hits", hit_count, 0);
    rst = 0;
    tick();
    chk("rst_in_ready", in_ready, 1);
    // zero mask
    in_valid = 1; in_mask = 32'h0;
    tick();
    in_valid = 0;
    chk("t1_done", done, 1);
    chk("t1_hits", hit_count, 0);
    chk("t1_valid", sel_valid, 0);
    chk("t1_ready", in_ready, 1);
    tick();
    chk("t1_done_clr", done, 0);
    // two extreme bits
    in_valid = 1; in_mask = 32'h8000_0001;
    tick();
    in_valid = 0;
    chk("t2_sel0", sel, 0);
    chk("t2_last0", sel_last, 0);
    tick();
    chk("t2_sel1", sel, 31);
    chk("t2_last1", sel_last, 1);
    tick();
    chk("t2_done", done, 1);
    chk("t2_hits", hit_count, 2);
    chk("t2_ready", in_ready, 1);
    tick();
    // full mask
    in_valid = 1; in_mask = 32'hFFFF_FFFF;
    tick();
    in_valid = 0;
    for (int i = 0; i < 32; i++) begin
      chk("t3_sel", sel, i);
      chk("t3_last", sel_last, i == 31);
      tick();
    end
    chk("t3_done", done, 1);
    chk("t3_hits", hit_count, 32);
    tick();
    // stall
    in_valid = 1; in_mask = 32'h0000_0050;
    tick();
    in_valid = 0;
    out_ready = 0;
    chk("t4_sel_first", sel, 4);
    repeat (3) begin
      tick();
      chk("t4_sel_hold", sel, 4);
      chk("t4_last_hold", sel_last, 0);
    end
    out_ready = 1;
    tick();
    chk("t4_sel_next", sel, 6);
    chk("t4_last", sel_last, 1);
    tick();
    chk("t4_done", done, 1);
    chk("t4_hits", hit_count, 2);
    tick();
    // in_valid during SCAN is ignored, then accepted on the done cycle
    in_valid = 1; in_mask = 32'h0003_0000;
    tick();
    in_mask = 32'h3;
    chk("t5_sel_a", sel, 16);
    chk("t5_busy", in_ready, 0);
    tick();
    chk("t5_sel_b", sel, 17);
    chk("t5_busy2", in_ready, 0);
    tick();
    chk("t5_done", done, 1);
    chk("t5_hits", hit_count, 2);
    chk("t5_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("t5_sel_c", sel, 0);
    chk("t5_done_clr", done, 0);
    tick();
    chk("t5_sel_d", sel, 1);
    chk("t5_last_d", sel_last, 1);
    tick();
    chk("t5_done2", done, 1);
    tick();
    // reset mid-frame
    in_valid = 1; in_mask = 32'h0000_F000;
    tick();
    in_valid = 0;
    chk("t6_sel12", sel, 12);
    tick();
    chk("t6_sel13", sel, 13);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_valid", sel_valid, 0);
    chk("t6_sel", sel, 0);
    chk("t6_last", sel_last, 0);
    chk("t6_done", done, 0);
    chk("t6_hits", hit_count, 0);
    tick();
    chk("t6_no_done", done, 0);
    chk("t6_ready", in_ready, 1);
    in_valid = 1; in_mask = 32'h4;
    tick();
    in_valid = 0;
    chk("t6_sel2", sel, 2);
    chk("t6_last2", sel_last, 1);
    tick();
    chk("t6_done2", done, 1);
    chk("t6_hits2", hit_count, 1);
    tick();
    // stalled frames checked by the model
    run_frame(32'hA5A5_0003);
    run_frame(32'h8000_0000);
    run_frame(32'h0001_0100);
    run_frame(32'h7FFF_FFFE);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule
